phase_sequencer: RTL and testbench

- Parametrised successor to the processor's fixed 5-phase control unit.
- Generates one-hot phase enables for the datapath from a free-running phase counter.
- Adds RUN/STEP/HALTED modes, edge-detected exec/step inputs, deferred halt at the instruction boundary, and a retired-instruction counter.
- Emits synchronous enables rather than gated clocks; the datapath uses them as clock enables on the single clock.

---
 rtl/phase_sequencer.sv | 109 ++++++++++
 tb/tb_phase_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: one-hot phase enables driven from a free-running phase
// counter, with RUN/STEP/HALTED modes, a halt deferred to the instruction boundary and a retired-instruction count.
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3,
    parameter int COUNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  step,
    input  logic                  halt,
    output logic                  register_reset,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  running,
    output logic                  halted,
    output logic [COUNT_W-1:0]    instr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t             state;
    logic               exec_q;
    logic               step_q;
    logic               exec_p;
    logic               step_p;
    logic               active;
    logic               last_phase;
    logic [PHASE_W-1:0] phase_next;

    assign register_reset = reset;

    assign exec_p     = exec & ~exec_q;
    assign step_p     = step & ~step_q;
    assign active     = (state == RUN) || (state == STEP);
    assign last_phase = (phase == LAST_PHASE);
    // An explicit wrap keeps phase below NUM_PHASES when it is not a power of two.
    assign phase_next = last_phase ? '0 : phase + PHASE_W'(1);

    assign running = active;
    assign halted  = (state == HALTED);

    always_comb begin
        phase_en = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            phase_en[i] = active && (phase == PHASE_W'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            instr_count <= '0;
            exec_q      <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            exec_q <= exec;
            step_q <= step;

            // The current phase always completes, even on the clock that leaves RUN or STEP.
            if (active) begin
                phase <= phase_next;
                if (last_phase) begin
                    instr_count <= instr_count + COUNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (exec_p) begin
                        state <= RUN;
                    end else if (step_p) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    if (exec_p) begin
                        state <= IDLE;
                    end else if (halt && last_phase) begin
                        state <= HALTED;
                    end
                end
                STEP: begin
                    if (last_phase) begin
                        state <= halt ? HALTED : IDLE;
                    end
                end
                HALTED: begin
                    if (exec_p) begin
                        state <= RUN;
                    end else if (step_p) begin
                        state <= STEP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: three parameterisations share one stimulus stream and are
// compared every clock against a per-instance mode/phase/count reference model.
module tb_phase_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic exec  = 1'b0;
    logic step  = 1'b0;
    logic halt  = 1'b0;

    logic       rr0, rr1, rr2;
    logic [2:0] ph0;
    logic [1:0] ph1;
    logic [2:0] ph2;
    logic [4:0] en0;
    logic [2:0] en1;
    logic [7:0] en2;
    logic       run0, run1, run2;
    logic       hlt0, hlt1, hlt2;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;

    always #5 clock = ~clock;

    phase_sequencer #(.NUM_PHASES(5), .PHASE_W(3), .COUNT_W(16)) u0 (
        .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt),
        .register_reset(rr0), .phase(ph0), .phase_en(en0), .running(run0),
        .halted(hlt0), .instr_count(cnt0));

    phase_sequencer #(.NUM_PHASES(3), .PHASE_W(2), .COUNT_W(4)) u1 (
        .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt),
        .register_reset(rr1), .phase(ph1), .phase_en(en1), .running(run1),
        .halted(hlt1), .instr_count(cnt1));

    phase_sequencer #(.NUM_PHASES(8), .PHASE_W(3), .COUNT_W(16)) u2 (
        .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt),
        .register_reset(rr2), .phase(ph2), .phase_en(en2), .running(run2),
        .halted(hlt2), .instr_count(cnt2));

    wire [31:0] o_phase [3];
    wire [31:0] o_en    [3];
    wire [31:0] o_run   [3];
    wire [31:0] o_hlt   [3];
    wire [31:0] o_cnt   [3];
    wire [31:0] o_rr    [3];

    assign o_phase[0] = 32'(ph0);  assign o_phase[1] = 32'(ph1);  assign o_phase[2] = 32'(ph2);
    assign o_en[0]    = 32'(en0);  assign o_en[1]    = 32'(en1);  assign o_en[2]    = 32'(en2);
    assign o_run[0]   = 32'(run0); assign o_run[1]   = 32'(run1); assign o_run[2]   = 32'(run2);
    assign o_hlt[0]   = 32'(hlt0); assign o_hlt[1]   = 32'(hlt1); assign o_hlt[2]   = 32'(hlt2);
    assign o_cnt[0]   = 32'(cnt0); assign o_cnt[1]   = 32'(cnt1); assign o_cnt[2]   = 32'(cnt2);
    assign o_rr[0]    = 32'(rr0);  assign o_rr[1]    = 32'(rr1);  assign o_rr[2]    = 32'(rr2);

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;
    int np [3] = '{5, 3, 8};
    int cw [3] = '{16, 4, 16};
    int md [3];
    int mph [3];
    int mcnt [3];
    bit prev_exec, prev_step;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            md[k] = M_IDLE; mph[k] = 0; mcnt[k] = 0;
        end
        prev_exec = 1'b0;
        prev_step = 1'b0;
    endtask

    task automatic model_clock();
        bit ep, sp, act, last;
        int nm;
        ep = exec && !prev_exec;
        sp = step && !prev_step;
        for (int k = 0; k < 3; k++) begin
            act  = (md[k] == M_RUN) || (md[k] == M_STEP);
            last = (mph[k] == np[k] - 1);
            nm   = md[k];
            case (md[k])
                M_IDLE:   if (ep) nm = M_RUN; else if (sp) nm = M_STEP;
                M_RUN:    if (ep) nm = M_IDLE; else if (halt && last) nm = M_HALTED;
                M_STEP:   if (last) nm = halt ? M_HALTED : M_IDLE;
                default:  if (ep) nm = M_RUN; else if (sp) nm = M_STEP;
            endcase
            if (act) begin
                if (last) mcnt[k] = (mcnt[k] + 1) % (1 << cw[k]);
                mph[k] = (mph[k] + 1) % np[k];
            end
            md[k] = nm;
        end
        prev_exec = exec;
        prev_step = step;
    endtask

    task automatic check_all();
        bit act;
        for (int k = 0; k < 3; k++) begin
            act = (md[k] == M_RUN) || (md[k] == M_STEP);
            check($sformatf("u%0d.phase", k), o_phase[k], 32'(mph[k]));
            check($sformatf("u%0d.phase_en", k), o_en[k], act ? (32'd1 << mph[k]) : 32'd0);
            check($sformatf("u%0d.running", k), o_run[k], 32'(act));
            check($sformatf("u%0d.halted", k), o_hlt[k], 32'(md[k] == M_HALTED));
            check($sformatf("u%0d.instr_count", k), o_cnt[k], 32'(mcnt[k]));
            check($sformatf("u%0d.register_reset", k), o_rr[k], 32'(reset));
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the model consumes the values seen at the edge.
    task automatic tick();
        if (reset) model_reset();
        else model_clock();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exec = 1'b0; step = 1'b0; halt = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_phase0(input int target);
        for (int i = 0; i < 20 && ph0 != 3'(target); i++) tick();
        check("wait_phase0", 32'(ph0), 32'(target));
    endtask

    initial begin
        model_reset();
        #1;

        // Reset to idle and hold
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        check("idle.phase", 32'(ph0), 32'd0);
        check("idle.phase_en", 32'(en0), 32'd0);
        check("idle.running", 32'(run0), 32'd0);
        check("idle.count", 32'(cnt0), 32'd0);

        // Held exec enters RUN once and stays there
        exec = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("held_exec.running", 32'(run0), 32'd1);
        check("held_exec.count", 32'(cnt0), 32'd3);
        exec = 1'b0;
        tick();

        // Continuous run from a clean reset
        do_reset();
        exec = 1'b1; tick(); exec = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("run_seq.phase_en", 32'(en0), 32'd1 << (i % 5));
            tick();
        end
        check("run.count_after_10", 32'(cnt0), 32'd2);

        // Pause at phase 2, resume mid-instruction
        wait_phase0(2);
        exec = 1'b1; tick(); exec = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pause.phase", 32'(ph0), 32'd3);
        check("pause.phase_en", 32'(en0), 32'd0);
        exec = 1'b1; tick(); exec = 1'b0;
        check("resume.phase_en", 32'(en0), 32'b01000);

        // Asynchronous reset in the middle of an instruction
        wait_phase0(3);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("async_reset.phase_en", 32'(en0), 32'd0);
        check("async_reset.running", 32'(run0), 32'd0);
        tick();
        reset = 1'b0;

        // Single step, with a step pulse inside the step ignored
        do_reset();
        step = 1'b1; tick(); step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("step.phase_en", 32'(en0), 32'd1 << i);
            if (i == 2) step = 1'b1;
            if (i == 3) step = 1'b0;
            tick();
        end
        check("step.running", 32'(run0), 32'd0);
        check("step.phase", 32'(ph0), 32'd0);
        check("step.count", 32'(cnt0), 32'd1);

        // Deferred halt at the instruction boundary
        do_reset();
        exec = 1'b1; tick(); exec = 1'b0;
        wait_phase0(1);
        halt = 1'b1;
        for (int i = 2; i < 5; i++) begin
            tick();
            check("halt.defer_phase", 32'(ph0), 32'(i));
        end
        tick();
        check("halt.halted", 32'(hlt0), 32'd1);
        check("halt.phase", 32'(ph0), 32'd0);
        halt = 1'b0;
        exec = 1'b1; tick(); exec = 1'b0;
        check("halt.resume_running", 32'(run0), 32'd1);
        check("halt.resume_phase", 32'(ph0), 32'd0);
        halt = 1'b1;
        for (int i = 0; i < 10 && !hlt0; i++) tick();
        check("halt.again", 32'(hlt0), 32'd1);
        halt = 1'b0;
        exec = 1'b1; step = 1'b1; tick(); exec = 1'b0; step = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("halt.both_pulse_run", 32'(run0), 32'd1);

        // Parameter sweep: short counter wrap and non-power-of-two phase range
        do_reset();
        exec = 1'b1; tick(); exec = 1'b0;
        for (int i = 1; i <= 49; i++) begin
            tick();
            check("u1.phase_range", 32'(ph1 < 2'd3), 32'd1);
            if (i == 45) check("u1.count_15", 32'(cnt1), 32'd15);
            if (i == 48) begin
                check("u1.count_wrap", 32'(cnt1), 32'd0);
                check("u2.count_48", 32'(cnt2), 32'd6);
                check("u2.phase_wrap", 32'(ph2), 32'd0);
            end
        end

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            exec = ($urandom_range(0, 5) == 0);
            step = ($urandom_range(0, 5) == 0);
            halt = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_all();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
